// File: rtl/frame_swap_controller_pkg.sv
// frame_swap_controller_pkg
// Shared widths, the controller state type and a small helper used by the
// double-buffer controller, its statistics block and its bus interface.
//   BUFFER_ADDR_WIDTH : frame buffer address width (160x120 words)
//   BUFFER_DATA_WIDTH : RGB444 pixel width
//   STAT_WIDTH        : width of the wrapping statistics counters
package frame_swap_controller_pkg;

  localparam int BUFFER_ADDR_WIDTH = 15;
  localparam int BUFFER_DATA_WIDTH = 12;
  localparam int STAT_WIDTH        = 16;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    DRAWING     = 3'd2,
    WAIT_VBLANK = 3'd3,
    SWAP        = 3'd4,
    PAUSED      = 3'd5,
    ACK         = 3'd6
  } frame_swap_state_t;

  // A vblank rising edge means the display repeated the old frame unless the
  // controller is already waiting to swap or has not started running.
  function automatic logic counts_as_late(input frame_swap_state_t state);
    return (state != WAIT_VBLANK) && (state != IDLE);
  endfunction

endpackage

// File: rtl/frame_swap_controller_if.sv
// frame_swap_controller_if
// Link between the drawing manager (master) and the frame swap controller
// (slave): the frame handshake plus the pixel write stream.
//   draw_start    : controller -> manager, one-cycle pulse starting frame one
//   frame_done    : manager -> controller, held high while frame is complete
//   draw_ack      : controller -> manager, one-cycle release to next frame
//   in_write_en   : manager -> controller, pixel write strobe
//   in_write_addr : manager -> controller, pixel address
//   in_write_data : manager -> controller, pixel colour
interface frame_swap_controller_if
  import frame_swap_controller_pkg::*;
();

  logic                         draw_start;
  logic                         frame_done;
  logic                         draw_ack;
  logic                         in_write_en;
  logic [BUFFER_ADDR_WIDTH-1:0] in_write_addr;
  logic [BUFFER_DATA_WIDTH-1:0] in_write_data;

  modport master (
    input  draw_start,
    input  draw_ack,
    output frame_done,
    output in_write_en,
    output in_write_addr,
    output in_write_data
  );

  modport slave (
    output draw_start,
    output draw_ack,
    input  frame_done,
    input  in_write_en,
    input  in_write_addr,
    input  in_write_data
  );

endinterface

// File: rtl/frame_swap_controller_stats.sv
// FrameStats
// Frame statistics for the double-buffer controller. Owns the delayed vblank
// used for edge detection and both wrapping counters.
//   clk, rst        : system clock, synchronous active-high reset
//   vblank          : display vertical-blanking level
//   state           : current controller state
//   frames_rendered : number of completed swaps
//   late_frames     : vblank rising edges that repeated the old frame
module FrameStats
  import frame_swap_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vblank,
  input  frame_swap_state_t     state,
  output logic [STAT_WIDTH-1:0] frames_rendered,
  output logic [STAT_WIDTH-1:0] late_frames
);

  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic                  vblank_q, vblank_d;
  logic [STAT_WIDTH-1:0] frames_rendered_q, frames_rendered_d;
  logic [STAT_WIDTH-1:0] late_frames_q, late_frames_d;
  logic                  vblank_rise;

  // One swap happens per cycle spent in SWAP; a late frame is a blanking
  // interval that starts while no finished frame is waiting for it.
  always_comb begin
    vblank_d          = vblank;
    vblank_rise       = vblank & ~vblank_q;
    frames_rendered_d = frames_rendered_q;
    late_frames_d     = late_frames_q;
    if (state == SWAP) begin
      frames_rendered_d = frames_rendered_q + STAT_ONE;
    end
    if (vblank_rise && counts_as_late(state)) begin
      late_frames_d = late_frames_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_q          <= 1'b0;
      frames_rendered_q <= '0;
      late_frames_q     <= '0;
    end else begin
      vblank_q          <= vblank_d;
      frames_rendered_q <= frames_rendered_d;
      late_frames_q     <= late_frames_d;
    end
  end

  assign frames_rendered = frames_rendered_q;
  assign late_frames     = late_frames_q;

endmodule

// File: rtl/frame_swap_controller.sv
// frame_swap_controller
// Double-buffer controller downstream of the drawing manager. Routes the
// pixel write stream into the current back buffer, runs the draw_start /
// frame_done / draw_ack handshake and swaps front and back buffers only
// during vertical blanking, at most once per blanking interval.
//   clk, rst         : system clock, synchronous active-high reset
//   enable           : run request, sampled in IDLE and SWAP/PAUSED
//   vblank           : display vertical-blanking level
//   draw_if          : handshake and write stream from the drawing manager
//   buf0/1_write_en  : per-buffer write strobes (registered)
//   buf_write_addr   : shared registered write address
//   buf_write_data   : shared registered write data
//   buffer_select    : back buffer index (being drawn)
//   display_select   : front buffer index, always ~buffer_select
//   frames_rendered  : completed swaps, wrapping
//   late_frames      : refreshes that repeated the old frame, wrapping
//   stray_write      : sticky, a write arrived outside DRAWING
module frame_swap_controller
  import frame_swap_controller_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         vblank,
  frame_swap_controller_if.slave       draw_if,
  output logic                         buf0_write_en,
  output logic                         buf1_write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] buf_write_data,
  output logic                         buffer_select,
  output logic                         display_select,
  output logic [STAT_WIDTH-1:0]        frames_rendered,
  output logic [STAT_WIDTH-1:0]        late_frames,
  output logic                         stray_write
);

  frame_swap_state_t state_q, state_d;

  logic draw_start_q, draw_start_d;
  logic draw_ack_q, draw_ack_d;
  logic buffer_select_q, buffer_select_d;
  logic blank_used_q, blank_used_d;
  logic stray_write_q, stray_write_d;
  logic buf0_write_en_q, buf0_write_en_d;
  logic buf1_write_en_q, buf1_write_en_d;
  logic [BUFFER_ADDR_WIDTH-1:0] buf_write_addr_q, buf_write_addr_d;
  logic [BUFFER_DATA_WIDTH-1:0] buf_write_data_q, buf_write_data_d;

  logic eligible;
  logic write_accept;

  // A swap is allowed only once per blanking interval; blank_used remembers
  // that this interval already produced one.
  assign eligible = vblank & ~blank_used_q;

  // Next-state logic; draw_start and draw_ack are computed one cycle early so
  // that they come out of flops in the START and ACK states.
  always_comb begin
    state_d         = state_q;
    draw_start_d    = 1'b0;
    draw_ack_d      = 1'b0;
    buffer_select_d = buffer_select_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d      = START;
          draw_start_d = 1'b1;
        end
      end
      START: begin
        state_d = DRAWING;
      end
      DRAWING: begin
        if (draw_if.frame_done) begin
          state_d = WAIT_VBLANK;
        end
      end
      WAIT_VBLANK: begin
        if (eligible) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        buffer_select_d = ~buffer_select_q;
        if (enable) begin
          state_d    = ACK;
          draw_ack_d = 1'b1;
        end else begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (enable) begin
          state_d    = ACK;
          draw_ack_d = 1'b1;
        end
      end
      ACK: begin
        state_d = DRAWING;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Low vblank always clears blank_used, so a new interval starts fresh even
  // if a swap landed on the last cycle of the previous one.
  always_comb begin
    blank_used_d = 1'b0;
    if (vblank) begin
      blank_used_d = blank_used_q | (state_q == SWAP);
    end
  end

  // Write stage: the target buffer is chosen from buffer_select at issue, so
  // a write in flight across a swap still lands in the old back buffer.
  always_comb begin
    write_accept     = draw_if.in_write_en && (state_q == DRAWING);
    buf0_write_en_d  = write_accept & ~buffer_select_q;
    buf1_write_en_d  = write_accept &  buffer_select_q;
    buf_write_addr_d = buf_write_addr_q;
    buf_write_data_d = buf_write_data_q;
    if (write_accept) begin
      buf_write_addr_d = draw_if.in_write_addr;
      buf_write_data_d = draw_if.in_write_data;
    end
    stray_write_d = stray_write_q | (draw_if.in_write_en && (state_q != DRAWING));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      draw_start_q     <= 1'b0;
      draw_ack_q       <= 1'b0;
      buffer_select_q  <= 1'b0;
      blank_used_q     <= 1'b0;
      stray_write_q    <= 1'b0;
      buf0_write_en_q  <= 1'b0;
      buf1_write_en_q  <= 1'b0;
      buf_write_addr_q <= '0;
      buf_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      draw_start_q     <= draw_start_d;
      draw_ack_q       <= draw_ack_d;
      buffer_select_q  <= buffer_select_d;
      blank_used_q     <= blank_used_d;
      stray_write_q    <= stray_write_d;
      buf0_write_en_q  <= buf0_write_en_d;
      buf1_write_en_q  <= buf1_write_en_d;
      buf_write_addr_q <= buf_write_addr_d;
      buf_write_data_q <= buf_write_data_d;
    end
  end

  FrameStats u_stats (
    .clk             (clk),
    .rst             (rst),
    .vblank          (vblank),
    .state           (state_q),
    .frames_rendered (frames_rendered),
    .late_frames     (late_frames)
  );

  assign draw_if.draw_start = draw_start_q;
  assign draw_if.draw_ack   = draw_ack_q;
  assign buf0_write_en      = buf0_write_en_q;
  assign buf1_write_en      = buf1_write_en_q;
  assign buf_write_addr     = buf_write_addr_q;
  assign buf_write_data     = buf_write_data_q;
  assign buffer_select      = buffer_select_q;
  assign display_select     = ~buffer_select_q;
  assign stray_write        = stray_write_q;

endmodule

// File: tb/tb_frame_swap_controller.sv
// tb_frame_swap_controller
// Directed bench for frame_swap_controller: a cycle table for reset, start
// and write routing, followed by hand-written multi-cycle sequences for
// vblank-gated swaps, late frames, pausing and mid-frame reset.
module tb_frame_swap_controller;
  import frame_swap_controller_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         enable;
  logic                         vblank;
  logic                         buf0_write_en;
  logic                         buf1_write_en;
  logic [BUFFER_ADDR_WIDTH-1:0] buf_write_addr;
  logic [BUFFER_DATA_WIDTH-1:0] buf_write_data;
  logic                         buffer_select;
  logic                         display_select;
  logic [STAT_WIDTH-1:0]        frames_rendered;
  logic [STAT_WIDTH-1:0]        late_frames;
  logic                         stray_write;

  frame_swap_controller_if draw_bus ();

  frame_swap_controller dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .vblank          (vblank),
    .draw_if         (draw_bus),
    .buf0_write_en   (buf0_write_en),
    .buf1_write_en   (buf1_write_en),
    .buf_write_addr  (buf_write_addr),
    .buf_write_data  (buf_write_data),
    .buffer_select   (buffer_select),
    .display_select  (display_select),
    .frames_rendered (frames_rendered),
    .late_frames     (late_frames),
    .stray_write     (stray_write)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic                         enable;
    logic                         write_en;
    logic [BUFFER_ADDR_WIDTH-1:0] addr;
    logic [BUFFER_DATA_WIDTH-1:0] data;
    logic                         exp_draw_start;
    logic                         exp_buf0;
    logic                         exp_buf1;
    logic [BUFFER_ADDR_WIDTH-1:0] exp_addr;
    logic [BUFFER_DATA_WIDTH-1:0] exp_data;
    logic                         exp_bsel;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mkVec(input logic en, input logic we,
                                 input logic [BUFFER_ADDR_WIDTH-1:0] a,
                                 input logic [BUFFER_DATA_WIDTH-1:0] d,
                                 input logic eds, input logic eb0, input logic eb1,
                                 input logic [BUFFER_ADDR_WIDTH-1:0] ea,
                                 input logic [BUFFER_DATA_WIDTH-1:0] ed,
                                 input logic ebs);
    vec_t v;
    v.enable = en; v.write_en = we; v.addr = a; v.data = d;
    v.exp_draw_start = eds; v.exp_buf0 = eb0; v.exp_buf1 = eb1;
    v.exp_addr = ea; v.exp_data = ed; v.exp_bsel = ebs;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    enable                 = v.enable;
    draw_bus.in_write_en   = v.write_en;
    draw_bus.in_write_addr = v.addr;
    draw_bus.in_write_data = v.data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic bad;

    rst = 1'b1; enable = 1'b0; vblank = 1'b0;
    draw_bus.frame_done = 1'b0; draw_bus.in_write_en = 1'b0;
    draw_bus.in_write_addr = '0; draw_bus.in_write_data = '0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset draw_start", 32'(draw_bus.draw_start), 32'd0);
    checkOutput("reset draw_ack", 32'(draw_bus.draw_ack), 32'd0);
    checkOutput("reset buf0_we", 32'(buf0_write_en), 32'd0);
    checkOutput("reset buf1_we", 32'(buf1_write_en), 32'd0);
    checkOutput("reset addr", 32'(buf_write_addr), 32'd0);
    checkOutput("reset data", 32'(buf_write_data), 32'd0);
    checkOutput("reset buffer_select", 32'(buffer_select), 32'd0);
    checkOutput("reset display_select", 32'(display_select), 32'd1);
    checkOutput("reset frames", 32'(frames_rendered), 32'd0);
    checkOutput("reset late", 32'(late_frames), 32'd0);
    checkOutput("reset stray", 32'(stray_write), 32'd0);

    // Cycle table: enable at row 5, draw_start after that edge only, then
    // writes in DRAWING routed to buffer 0.
    for (int i = 0; i < 5; i++) begin
      vecs[i] = mkVec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    vecs[5]  = mkVec(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    vecs[6]  = mkVec(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    vecs[7]  = mkVec(1'b1, 1'b1, 15'h1234, 12'hF00, 1'b0, 1'b1, 1'b0, 15'h1234, 12'hF00, 1'b0);
    vecs[8]  = mkVec(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 15'h1234, 12'hF00, 1'b0);
    vecs[9]  = mkVec(1'b1, 1'b1, 15'h0ABC, 12'h0AB, 1'b0, 1'b1, 1'b0, 15'h0ABC, 12'h0AB, 1'b0);
    vecs[10] = mkVec(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 15'h0ABC, 12'h0AB, 1'b0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("row%0d draw_start", i), 32'(draw_bus.draw_start), 32'(vecs[i].exp_draw_start));
      checkOutput($sformatf("row%0d buf0_we", i), 32'(buf0_write_en), 32'(vecs[i].exp_buf0));
      checkOutput($sformatf("row%0d buf1_we", i), 32'(buf1_write_en), 32'(vecs[i].exp_buf1));
      checkOutput($sformatf("row%0d addr", i), 32'(buf_write_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("row%0d data", i), 32'(buf_write_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("row%0d buffer_select", i), 32'(buffer_select), 32'(vecs[i].exp_bsel));
    end

    // Frame done with vblank low for 100 cycles, then vblank rises.
    draw_bus.frame_done = 1'b1;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (draw_bus.draw_ack !== 1'b0 || buffer_select !== 1'b0 || frames_rendered !== 16'd0) bad = 1'b1;
    end
    checkOutput("seqA no swap while vblank low", 32'(bad), 32'd0);
    vblank = 1'b1;
    tick();
    checkOutput("seqA swap cycle buffer_select", 32'(buffer_select), 32'd0);
    checkOutput("seqA swap cycle draw_ack", 32'(draw_bus.draw_ack), 32'd0);
    tick();
    checkOutput("seqA buffer_select", 32'(buffer_select), 32'd1);
    checkOutput("seqA display_select", 32'(display_select), 32'd0);
    checkOutput("seqA draw_ack", 32'(draw_bus.draw_ack), 32'd1);
    checkOutput("seqA frames", 32'(frames_rendered), 32'd1);
    draw_bus.frame_done = 1'b0;
    tick();
    checkOutput("seqA draw_ack one cycle", 32'(draw_bus.draw_ack), 32'd0);
    draw_bus.in_write_en = 1'b1; draw_bus.in_write_addr = 15'h7FFF; draw_bus.in_write_data = 12'hFFF;
    tick();
    draw_bus.in_write_en = 1'b0;
    checkOutput("seqA buf1_we", 32'(buf1_write_en), 32'd1);
    checkOutput("seqA buf0_we", 32'(buf0_write_en), 32'd0);
    checkOutput("seqA addr", 32'(buf_write_addr), 32'h7FFF);
    checkOutput("seqA late", 32'(late_frames), 32'd0);

    // Second frame finishes within the same blanking interval.
    draw_bus.frame_done = 1'b1;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (draw_bus.draw_ack !== 1'b0 || buffer_select !== 1'b1) bad = 1'b1;
    end
    checkOutput("seqB no second swap in interval", 32'(bad), 32'd0);
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    vblank = 1'b1;
    tick();
    checkOutput("seqB swap cycle draw_ack", 32'(draw_bus.draw_ack), 32'd0);
    tick();
    checkOutput("seqB draw_ack", 32'(draw_bus.draw_ack), 32'd1);
    checkOutput("seqB buffer_select", 32'(buffer_select), 32'd0);
    checkOutput("seqB frames", 32'(frames_rendered), 32'd2);
    checkOutput("seqB late", 32'(late_frames), 32'd0);
    draw_bus.frame_done = 1'b0;
    tick();

    // Drawing spans three vblank rising edges.
    bad = 1'b0;
    for (int p = 0; p < 3; p++) begin
      vblank = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (display_select !== 1'b1) bad = 1'b1;
      end
      vblank = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (display_select !== 1'b1) bad = 1'b1;
      end
    end
    checkOutput("seqC display_select steady", 32'(bad), 32'd0);
    checkOutput("seqC late", 32'(late_frames), 32'd3);
    checkOutput("seqC frames", 32'(frames_rendered), 32'd2);
    vblank = 1'b0;
    tick();

    // enable low at SWAP: pause, stray write, then release.
    draw_bus.frame_done = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    checkOutput("seqD swap cycle draw_ack", 32'(draw_bus.draw_ack), 32'd0);
    tick();
    checkOutput("seqD paused draw_ack", 32'(draw_bus.draw_ack), 32'd0);
    checkOutput("seqD buffer_select", 32'(buffer_select), 32'd1);
    checkOutput("seqD frames", 32'(frames_rendered), 32'd3);
    checkOutput("seqD stray before", 32'(stray_write), 32'd0);
    draw_bus.in_write_en = 1'b1; draw_bus.in_write_addr = 15'h0055; draw_bus.in_write_data = 12'h123;
    tick();
    draw_bus.in_write_en = 1'b0;
    checkOutput("seqD stray set", 32'(stray_write), 32'd1);
    checkOutput("seqD no buf0 write", 32'(buf0_write_en), 32'd0);
    checkOutput("seqD no buf1 write", 32'(buf1_write_en), 32'd0);
    checkOutput("seqD addr held", 32'(buf_write_addr), 32'h7FFF);
    bad = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (draw_bus.draw_ack !== 1'b0) bad = 1'b1;
    end
    checkOutput("seqD no ack while paused", 32'(bad), 32'd0);
    enable = 1'b1;
    tick();
    checkOutput("seqD draw_ack on release", 32'(draw_bus.draw_ack), 32'd1);
    draw_bus.frame_done = 1'b0;
    tick();
    checkOutput("seqD draw_ack one cycle", 32'(draw_bus.draw_ack), 32'd0);
    checkOutput("seqD late", 32'(late_frames), 32'd3);
    checkOutput("seqD stray sticky", 32'(stray_write), 32'd1);

    // Reset mid-frame clears everything on the next edge.
    draw_bus.in_write_en = 1'b1; draw_bus.in_write_addr = 15'h0011; draw_bus.in_write_data = 12'h022;
    rst = 1'b1;
    tick();
    rst = 1'b0; enable = 1'b0; draw_bus.in_write_en = 1'b0; vblank = 1'b0;
    checkOutput("rstE buf0_we", 32'(buf0_write_en), 32'd0);
    checkOutput("rstE buf1_we", 32'(buf1_write_en), 32'd0);
    checkOutput("rstE addr", 32'(buf_write_addr), 32'd0);
    checkOutput("rstE buffer_select", 32'(buffer_select), 32'd0);
    checkOutput("rstE frames", 32'(frames_rendered), 32'd0);
    checkOutput("rstE late", 32'(late_frames), 32'd0);
    checkOutput("rstE stray", 32'(stray_write), 32'd0);
    tick();
    checkOutput("rstE idle no draw_start", 32'(draw_bus.draw_start), 32'd0);
    enable = 1'b1;
    tick();
    checkOutput("rstE restart draw_start", 32'(draw_bus.draw_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
